// File: rtl/fib_pkg.sv
// Shared types and constants for the FBC Fibonacci engine.
// F(0)=F(1)=FIB_BASE; larger indices iterate in fib_seq_engine.
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } fib_state_e;

  localparam int FIB_BASE         = 1;
  localparam int FIB_BASE_MAX_IDX = 1;

endpackage

// File: rtl/fib_sat_add.sv
// Combinational WIDTH-bit adder with carry out and optional clamp.
// Clamp holds all-ones once a run has overflowed (sat_in) or carries now.
module fib_sat_add
  import fib_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sat_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH:0] full;

  assign full  = {1'b0, a} + {1'b0, b};
  assign carry = full[WIDTH];

  always_comb begin
    sum = full[WIDTH-1:0];
    if (SATURATE && (carry || sat_in))
      sum = '1;
  end

endmodule

// File: rtl/fib_seq_engine.sv
// Sequential Fibonacci engine for FBC: one addition per clock,
// holding the EXEC state until the final term is written to ACC.
module fib_seq_engine
  import fib_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int NW       = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NW-1:0]    n_in,
  input  logic             abort,
  output logic             busy,
  output logic             exec_hold,
  output logic             done,
  output logic             result_we,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  fib_state_e state, state_nxt;

  logic [WIDTH-1:0] a, b;
  logic [NW-1:0]    k, target;
  logic             ovf_run;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             accept;
  logic             base;
  logic             last;

  assign accept = start & ~abort &
                  ((state == IDLE) | (state == DONE));
  assign base   = (n_in <= NW'(FIB_BASE_MAX_IDX));
  assign last   = (k == target);

  assign busy      = (state == ITER);
  assign done      = (state == DONE);
  assign result_we = done;
  assign exec_hold = busy | accept;

  fib_sat_add #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_add (
    .a      (a),
    .b      (b),
    .sat_in (ovf_run),
    .sum    (sum),
    .carry  (carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (accept)
          state_nxt = base ? DONE : ITER;
        else
          state_nxt = IDLE;
      end
      ITER: begin
        if (abort)
          state_nxt = IDLE;
        else if (last)
          state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // result/overflow only change on completion, so an abort keeps the old run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a        <= '0;
      b        <= '0;
      k        <= '0;
      target   <= '0;
      ovf_run  <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      ovf_run <= 1'b0;
      if (base) begin
        result   <= WIDTH'(FIB_BASE);
        overflow <= 1'b0;
      end else begin
        a      <= WIDTH'(FIB_BASE);
        b      <= WIDTH'(FIB_BASE);
        k      <= NW'(2);
        target <= n_in;
      end
    end else if (busy && !abort) begin
      a       <= b;
      b       <= sum;
      ovf_run <= ovf_run | carry;
      if (last) begin
        result   <= sum;
        overflow <= ovf_run | carry;
      end else begin
        k <= k + NW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fib_seq_engine.sv
// Directed bench for fib_seq_engine: wrap and saturating instances
// share stimulus; table of runs plus multi-cycle corner sequences.
module tb_fib_seq_engine;

  localparam int W  = 16;
  localparam int NW = 16;
  localparam int LIMIT = 200;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [NW-1:0] n_in;
  logic          abort;

  logic          busy, exec_hold, done, result_we, overflow;
  logic [W-1:0]  result;
  logic          s_busy, s_hold, s_done, s_we, s_ovf;
  logic [W-1:0]  s_result;

  int errors = 0;
  int checks = 0;

  fib_seq_engine #(.WIDTH(W), .NW(NW), .SATURATE(1'b0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .n_in      (n_in),
    .abort     (abort),
    .busy      (busy),
    .exec_hold (exec_hold),
    .done      (done),
    .result_we (result_we),
    .result    (result),
    .overflow  (overflow)
  );

  fib_seq_engine #(.WIDTH(W), .NW(NW), .SATURATE(1'b1)) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .n_in      (n_in),
    .abort     (abort),
    .busy      (s_busy),
    .exec_hold (s_hold),
    .done      (s_done),
    .result_we (s_we),
    .result    (s_result),
    .overflow  (s_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int n;
    int res;
    int ovf;
    int sat_res;
    int sat_ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive start in the current cycle, then follow the run to done.
  task automatic run(input int n, output int lat, output int bcnt,
                     output int hold_bad);
    n_in  = NW'(n);
    start = 1'b1;
    #1;
    chk($sformatf("hold_at_start n=%0d", n), 32'(exec_hold), 32'd1);
    step();
    start = 1'b0;
    lat = 1;
    bcnt = 0;
    hold_bad = 0;
    while (done !== 1'b1 && lat < LIMIT) begin
      if (busy === 1'b1) bcnt++;
      if (exec_hold !== 1'b1) hold_bad++;
      step();
      lat++;
    end
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL timeout n=%0d: got no done expected done", n);
    end
  endtask

  int lat, bc, hb, exp_lat, exp_bc, cyc;
  bit seen;

  initial begin
    vecs[0] = '{0, 1, 0, 1, 0};
    vecs[1] = '{1, 1, 0, 1, 0};
    vecs[2] = '{2, 2, 0, 2, 0};
    vecs[3] = '{3, 3, 0, 3, 0};
    vecs[4] = '{5, 8, 0, 8, 0};
    vecs[5] = '{10, 89, 0, 89, 0};
    vecs[6] = '{23, 46368, 0, 46368, 0};
    vecs[7] = '{24, 9489, 1, 65535, 1};
    vecs[8] = '{25, 55857, 1, 65535, 1};

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    n_in  = '0;
    #12;
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset we", 32'(result_we), 0);
    chk("reset result", 32'(result), 0);
    chk("reset ovf", 32'(overflow), 0);
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      exp_lat = (vecs[i].n < 1) ? 1 : vecs[i].n;
      exp_bc  = exp_lat - 1;
      run(vecs[i].n, lat, bc, hb);
      chk($sformatf("latency n=%0d", vecs[i].n), 32'(lat), 32'(exp_lat));
      chk($sformatf("busy cycles n=%0d", vecs[i].n), 32'(bc), 32'(exp_bc));
      chk($sformatf("hold gaps n=%0d", vecs[i].n), 32'(hb), 0);
      chk($sformatf("we n=%0d", vecs[i].n), 32'(result_we), 1);
      chk($sformatf("result n=%0d", vecs[i].n), 32'(result),
          32'(vecs[i].res));
      chk($sformatf("ovf n=%0d", vecs[i].n), 32'(overflow),
          32'(vecs[i].ovf));
      chk($sformatf("sat result n=%0d", vecs[i].n), 32'(s_result),
          32'(vecs[i].sat_res));
      chk($sformatf("sat ovf n=%0d", vecs[i].n), 32'(s_ovf),
          32'(vecs[i].sat_ovf));
      step();
      chk($sformatf("done width n=%0d", vecs[i].n), 32'(done), 0);
      chk($sformatf("hold held n=%0d", vecs[i].n), 32'(result), 32'(vecs[i].res));
      step();
    end

    // abort beats start in IDLE
    n_in  = NW'(4);
    start = 1'b1;
    abort = 1'b1;
    #1;
    chk("abort idle hold", 32'(exec_hold), 0);
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("abort idle busy", 32'(busy), 0);
    chk("abort idle done", 32'(done), 0);

    // abort on 5th ITER cycle keeps prior run (n=25: 55857, ovf=1)
    n_in  = NW'(20);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    chk("pre-abort busy", 32'(busy), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("post-abort busy", 32'(busy), 0);
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (done === 1'b1) seen = 1'b1;
      step();
    end
    chk("abort no done", 32'(seen), 0);
    chk("abort result kept", 32'(result), 32'd55857);
    chk("abort ovf kept", 32'(overflow), 1);

    // a start during ITER is ignored
    n_in  = NW'(6);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    n_in  = NW'(2);
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 3;
    while (done !== 1'b1 && cyc < LIMIT) begin
      step();
      cyc++;
    end
    chk("ignored start latency", 32'(cyc), 6);
    chk("ignored start result", 32'(result), 13);
    step();
    step();

    // back-to-back: n=5 then n=3 accepted in the DONE cycle
    run(5, lat, bc, hb);
    chk("b2b first result", 32'(result), 8);
    n_in  = NW'(3);
    start = 1'b1;
    #1;
    chk("b2b hold in done", 32'(exec_hold), 1);
    step();
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < LIMIT) begin
      chk("b2b old result held", 32'(result), 8);
      step();
      cyc++;
    end
    chk("b2b second latency", 32'(cyc), 3);
    chk("b2b second result", 32'(result), 3);
    chk("b2b second ovf", 32'(overflow), 0);
    step();

    // overflowing run then base case in DONE clears overflow
    run(24, lat, bc, hb);
    chk("b2b ovf set", 32'(overflow), 1);
    n_in  = NW'(1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("b2b base done", 32'(done), 1);
    chk("b2b base result", 32'(result), 1);
    chk("b2b base ovf clr", 32'(overflow), 0);
    step();

    // async reset between edges mid-ITER
    n_in  = NW'(20);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst busy", 32'(busy), 0);
    chk("arst hold", 32'(exec_hold), 0);
    chk("arst done", 32'(done), 0);
    chk("arst result", 32'(result), 0);
    chk("arst ovf", 32'(overflow), 0);
    step();
    rst_n = 1'b1;
    step();
    run(2, lat, bc, hb);
    chk("post-rst latency", 32'(lat), 2);
    chk("post-rst result", 32'(result), 2);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
